// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial W-bit adder. A single 1-bit full-adder cell, built from two half
// adders with OR-combined carries, is stepped over the operands LSB first.
// One addition takes W cycles in RUN. It is followed by one DONE cycle, so
// back-to-back operation gives one result every W+1 cycles.
//
// Optional feature macro: SERIAL_ADD_CTRL_OVF_EN
//   defined   -> ovf is the registered signed-overflow flag of the last result
//   undefined -> ovf is tied to 0 and no overflow logic exists
//
// Ports
//   clk    in   1  clock, rising edge
//   rst_n  in   1  synchronous active-low reset
//   start  in   1  request one addition (accepted in IDLE or DONE)
//   a      in   W  operand A, sampled when start is accepted
//   b      in   W  operand B, sampled when start is accepted
//   sum    out  W  registered (A+B) mod 2^W
//   carry  out  1  registered carry-out of the W-bit addition
//   busy   out  1  high while the addition is in progress
//   done   out  1  one-cycle pulse: sum/carry/ovf are valid
//   ovf    out  1  signed overflow of the last result
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         carry,
   output logic         busy,
   output logic         done,
   output logic         ovf
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    opA_q, opA_d;
   logic [W-1:0]    opB_q, opB_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            runCarry_q, runCarry_d;
   logic            carry_q, carry_d;

   logic            haSum1, haCarry1, cellSum, haCarry2, cellCarry;
   logic            lastBit, acceptStart;

   // The adder cell: first half adder combines the operand bits, the second
   // folds in the running carry; either half adder can generate the carry-out.
   assign haSum1    = opA_q[0] ^ opB_q[0];
   assign haCarry1  = opA_q[0] & opB_q[0];
   assign cellSum   = haSum1 ^ runCarry_q;
   assign haCarry2  = haSum1 & runCarry_q;
   assign cellCarry = haCarry1 | haCarry2;

   // The counter holds the index of the bit being added, so the W-th RUN edge
   // is the one where it reads W-1.
   assign lastBit     = (cnt_q == CW'(W - 1));
   assign acceptStart = start && ((state_q == IDLE) || (state_q == DONE));

   // Next-state logic. DONE lasts exactly one cycle; a start seen there chains
   // straight into the next run. The unused code falls back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (lastBit) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state. Results are only touched by an accepted start
   // (operands/carry reload) or by RUN edges, so they hold in IDLE and DONE.
   // The sum bit enters at the MSB so that after W shifts bit 0 sits at bit 0.
   always_comb begin
      cnt_d      = cnt_q;
      opA_d      = opA_q;
      opB_d      = opB_q;
      sum_d      = sum_q;
      runCarry_d = runCarry_q;
      carry_d    = carry_q;
      if (acceptStart) begin
         opA_d      = a;
         opB_d      = b;
         cnt_d      = '0;
         runCarry_d = 1'b0;
      end else if (state_q == RUN) begin
         sum_d      = {cellSum, sum_q[W-1:1]};
         opA_d      = opA_q >> 1;
         opB_d      = opB_q >> 1;
         runCarry_d = cellCarry;
         cnt_d      = cnt_q + CW'(1);
         if (lastBit) carry_d = cellCarry;
      end
   end

   // State and datapath registers with synchronous reset that wins over start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         opA_q      <= '0;
         opB_q      <= '0;
         sum_q      <= '0;
         runCarry_q <= 1'b0;
         carry_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         opA_q      <= opA_d;
         opB_q      <= opB_d;
         sum_q      <= sum_d;
         runCarry_q <= runCarry_d;
         carry_q    <= carry_d;
      end
   end

`ifdef SERIAL_ADD_CTRL_OVF_EN
   logic ovf_q, ovf_d;

   // On the MSB step the running carry is the carry into the MSB and the cell
   // carry is the carry out of it; they differ exactly on signed overflow.
   always_comb begin
      ovf_d = ovf_q;
      if ((state_q == RUN) && lastBit) ovf_d = runCarry_q ^ cellCarry;
   end

   // Overflow flag register, held between results like sum.
   always_ff @(posedge clk) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign sum   = sum_q;
   assign carry = carry_q;
   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl with W=8. Inputs change #1 after a rising
// edge and outputs are observed at that same point, so each check sees the
// state registered by the edge just taken.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int W = 8;

`ifdef SERIAL_ADD_CTRL_OVF_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] sum;
   logic         carry;
   logic         busy;
   logic         done;
   logic         ovf;

   int compareCount = 0;
   int failCount    = 0;

   serial_add_ctrl #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .sum   (sum),
      .carry (carry),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so a broken DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic applyStimulus(input logic s, input logic [W-1:0] av,
                                input logic [W-1:0] bv);
      start = s;
      a     = av;
      b     = bv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete addition from an idle/done block: start at edge 0, busy for
   // the next W cycles, done after edge W, then results held a cycle later.
   task automatic runAdd(input string tag, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] expSum,
                         input logic expCarry, input logic expOvf);
      applyStimulus(1'b1, av, bv);
      tick();
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b0, W'($urandom), W'($urandom));
         checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
         checkOutput({tag, "_nodone"}, {31'b0, done}, 32'd0);
         tick();
      end
      checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
      checkOutput({tag, "_idlebusy"}, {31'b0, busy}, 32'd0);
      checkOutput({tag, "_sum"}, {24'b0, sum}, {24'b0, expSum});
      checkOutput({tag, "_carry"}, {31'b0, carry}, {31'b0, expCarry});
      checkOutput({tag, "_ovf"}, {31'b0, ovf}, {31'b0, expOvf});
      tick();
      checkOutput({tag, "_donepulse"}, {31'b0, done}, 32'd0);
      checkOutput({tag, "_sumheld"}, {24'b0, sum}, {24'b0, expSum});
      checkOutput({tag, "_carryheld"}, {31'b0, carry}, {31'b0, expCarry});
   endtask

   // Directed scenario sequence.
   initial begin
      int doneCount;

      rst_n = 1'b0;
      applyStimulus(1'b1, 8'hA5, 8'h5A);
      tick();
      tick();
      checkOutput("reset_sum", {24'b0, sum}, 32'd0);
      checkOutput("reset_carry", {31'b0, carry}, 32'd0);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_ovf", {31'b0, ovf}, 32'd0);

      // Idle without start stays idle.
      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00);
      tick();
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);

      runAdd("basic", 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
      runAdd("wrap", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

      // Reset at edge 4 of a run: outputs clear, no done ever appears, and
      // start on the first edge after release is honoured.
      applyStimulus(1'b1, 8'h0F, 8'h0F);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      tick();
      tick();
      tick();
      checkOutput("rstmid_prebusy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      checkOutput("rstmid_sum", {24'b0, sum}, 32'd0);
      checkOutput("rstmid_carry", {31'b0, carry}, 32'd0);
      checkOutput("rstmid_busy", {31'b0, busy}, 32'd0);
      checkOutput("rstmid_done", {31'b0, done}, 32'd0);
      checkOutput("rstmid_ovf", {31'b0, ovf}, 32'd0);
      doneCount = 0;
      for (int i = 0; i < W + 2; i++) begin
         tick();
         if (done) doneCount++;
      end
      checkOutput("rstmid_nodone", doneCount, 32'd0);
      rst_n = 1'b1;

      runAdd("sovf", 8'h7F, 8'h01, 8'h80, 1'b0, OVF_EN);

      // Start while busy is ignored: only one done, for 03+04.
      applyStimulus(1'b1, 8'h03, 8'h04);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      tick();
      tick();
      applyStimulus(1'b1, 8'hAA, 8'h55);
      tick();
      applyStimulus(1'b0, 8'hAA, 8'h55);
      checkOutput("busystart_busy", {31'b0, busy}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("busystart_nodone", {31'b0, done}, 32'd0);
         tick();
      end
      checkOutput("busystart_done", {31'b0, done}, 32'd1);
      checkOutput("busystart_sum", {24'b0, sum}, 32'h07);
      checkOutput("busystart_carry", {31'b0, carry}, 32'd0);
      doneCount = 0;
      for (int i = 0; i < 2 * W; i++) begin
         tick();
         if (done || busy) doneCount++;
      end
      checkOutput("busystart_single", doneCount, 32'd0);

      // Back-to-back with start held: dones 9 cycles apart.
      applyStimulus(1'b1, 8'h01, 8'h01);
      tick();
      applyStimulus(1'b1, 8'h10, 8'h20);
      for (int i = 0; i < W; i++) begin
         checkOutput("b2b1_busy", {31'b0, busy}, 32'd1);
         tick();
      end
      checkOutput("b2b1_done", {31'b0, done}, 32'd1);
      checkOutput("b2b1_excl", {31'b0, busy}, 32'd0);
      checkOutput("b2b1_sum", {24'b0, sum}, 32'h02);
      checkOutput("b2b1_carry", {31'b0, carry}, 32'd0);
      tick();
      applyStimulus(1'b0, 8'hFF, 8'hFF);
      for (int i = 0; i < W; i++) begin
         checkOutput("b2b2_busy", {31'b0, busy}, 32'd1);
         checkOutput("b2b2_nodone", {31'b0, done}, 32'd0);
         tick();
      end
      checkOutput("b2b2_done", {31'b0, done}, 32'd1);
      checkOutput("b2b2_sum", {24'b0, sum}, 32'h30);
      checkOutput("b2b2_carry", {31'b0, carry}, 32'd0);
      checkOutput("b2b2_ovf", {31'b0, ovf}, 32'd0);
      tick();
      checkOutput("b2b2_idle", {30'b0, busy, done}, 32'd0);
      checkOutput("b2b2_sumheld", {24'b0, sum}, 32'h30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
